// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : phase encodings and payload-length decode for the framer  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_START  = 3'd1,
        PH_DATA   = 3'd2,
        PH_PARITY = 3'd3,
        PH_STOP   = 3'd4
    } phase_e;

    localparam logic [2:0] C_LAST_IDX_LEN5 = 3'd4;
    localparam logic [2:0] C_LAST_IDX_LEN6 = 3'd5;
    localparam logic [2:0] C_LAST_IDX_LEN7 = 3'd6;
    localparam logic [2:0] C_LAST_IDX_LEN8 = 3'd7;

    function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
        logic [2:0] idx;
        case (len)
            2'd0:    idx = C_LAST_IDX_LEN5;
            2'd1:    idx = C_LAST_IDX_LEN6;
            2'd2:    idx = C_LAST_IDX_LEN7;
            default: idx = C_LAST_IDX_LEN8;
        endcase
        return idx;
    endfunction

    function automatic logic [7:0] payload_mask(input logic [1:0] len);
        logic [7:0] mask;
        case (len)
            2'd0:    mask = 8'h1F;
            2'd1:    mask = 8'h3F;
            2'd2:    mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_tick : bit-period divider, ticks on the last cycle of a bit |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int CLK_DIV = 16,
    parameter int DIV_W   = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam logic [DIV_W-1:0] C_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (restart || (cnt_q == C_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_framer : configurable 5..8 bit UART transmit framer          |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DIV_W   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       start,
    input  logic [7:0] data,
    input  logic [1:0] data_len,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       two_stop,
    output logic       txd,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] phase,
    output logic [2:0] bit_idx
);

    phase_e     state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop2_q, stop2_d;
    logic [7:0] data_q, data_d;
    logic [1:0] len_q, len_d;
    logic       par_en_q, par_en_d;
    logic       par_odd_q, par_odd_d;
    logic       two_stop_q, two_stop_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;

    logic       w_tick;
    logic       w_frame_done;
    logic       w_accept;
    logic       w_restart;
    logic       w_parity;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Back-to-back acceptance happens in the final stop cycle, so it outranks STOP->IDLE.
    always_comb begin
        w_frame_done = (state_q == PH_STOP) && w_tick && (!two_stop_q || stop2_q);
        w_accept     = start && !clear && ((state_q == PH_IDLE) || w_frame_done);
        w_restart    = clear || w_accept || (state_q == PH_IDLE);
    end

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop2_d    = stop2_q;
        data_d     = data_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;

        if (clear) begin
            state_d   = PH_IDLE;
            bit_idx_d = 3'd0;
            stop2_d   = 1'b0;
        end else if (w_accept) begin
            state_d    = PH_START;
            bit_idx_d  = 3'd0;
            stop2_d    = 1'b0;
            data_d     = data;
            len_d      = data_len;
            par_en_d   = parity_en;
            par_odd_d  = parity_odd;
            two_stop_d = two_stop;
        end else if (w_tick) begin
            case (state_q)
                PH_START: begin
                    state_d   = PH_DATA;
                    bit_idx_d = 3'd0;
                end
                PH_DATA: begin
                    if (bit_idx_q == last_bit_idx(len_q)) begin
                        state_d   = par_en_q ? PH_PARITY : PH_STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                PH_PARITY: state_d = PH_STOP;
                PH_STOP: begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = PH_IDLE;
                        stop2_d = 1'b0;
                    end
                end
                default: state_d = PH_IDLE;
            endcase
        end
    end

    // txd is computed from the next state so the line value is registered.
    always_comb begin
        w_parity = (^(data_d & payload_mask(len_d))) ^ par_odd_d;
        busy_d   = (state_d != PH_IDLE);
        case (state_d)
            PH_START:  txd_d = 1'b0;
            PH_DATA:   txd_d = data_d[bit_idx_d];
            PH_PARITY: txd_d = w_parity;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PH_IDLE;
            bit_idx_q  <= 3'd0;
            stop2_q    <= 1'b0;
            data_q     <= 8'd0;
            len_q      <= 2'd0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop2_q    <= stop2_d;
            data_q     <= data_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign frame_done = w_frame_done;
    assign phase      = state_q;
    assign bit_idx    = bit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_uart_tx_framer : self-checking bench for uart_tx_framer (DIV=4)   |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_framer;

    localparam int CLK_DIV = 4;

    typedef logic [11:0] bits_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] len;
        logic       pe;
        logic       po;
        logic       ts;
        bits_t      bits;
        int         nbits;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = 8'd0;
    logic [1:0] data_len = 2'd0;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       txd;
    logic       busy;
    logic       frame_done;
    logic [2:0] phase;
    logic [2:0] bit_idx;

    int checks = 0;
    int errors = 0;

    uart_tx_framer #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .start      (start),
        .data       (data),
        .data_len   (data_len),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done),
        .phase      (phase),
        .bit_idx    (bit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference line sequence: start, N payload bits LSB first, optional parity, stop bit(s).
    function automatic void model_frame(input logic [7:0] d, input logic [1:0] len,
                                        input logic pe, input logic po, input logic ts,
                                        output bits_t bits, output int nbits);
        int   n;
        logic p;
        n     = int'(len) + 5;
        p     = po;
        bits  = '0;
        nbits = 0;
        bits[nbits] = 1'b0;
        nbits++;
        for (int i = 0; i < n; i++) begin
            bits[nbits] = d[i];
            p = p ^ d[i];
            nbits++;
        end
        if (pe) begin
            bits[nbits] = p;
            nbits++;
        end
        bits[nbits] = 1'b1;
        nbits++;
        if (ts) begin
            bits[nbits] = 1'b1;
            nbits++;
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".idle_phase"}, 32'(phase), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".idle_txd"}, 32'(txd), 32'd1);
        chk({tag, ".idle_done"}, 32'(frame_done), 32'd0);
        chk({tag, ".idle_bitidx"}, 32'(bit_idx), 32'd0);
    endtask

    // Called from idle at 1ns after an edge; returns 1ns after the edge following frame_done.
    task automatic run_frame(input string tag, input vec_t v, input bit poke);
        int total;
        int b;
        int n;
        total      = v.nbits * CLK_DIV;
        n          = int'(v.len) + 5;
        data       = v.d;
        data_len   = v.len;
        parity_en  = v.pe;
        parity_odd = v.po;
        two_stop   = v.ts;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < total; k++) begin
            b = k / CLK_DIV;
            chk({tag, ".txd"}, 32'(txd), 32'(v.bits[b]));
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".frame_done"}, 32'(frame_done), 32'(k == total - 1));
            if (b == 0) chk({tag, ".phase_start"}, 32'(phase), 32'd1);
            if (b >= 1 && b <= n) begin
                chk({tag, ".phase_data"}, 32'(phase), 32'd2);
                chk({tag, ".bit_idx"}, 32'(bit_idx), 32'(b - 1));
            end else begin
                chk({tag, ".bit_idx0"}, 32'(bit_idx), 32'd0);
            end
            if (poke) begin
                start      = (k < total - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                data       = 8'($urandom);
                data_len   = 2'($urandom);
                parity_en  = 1'($urandom);
                parity_odd = 1'($urandom);
                two_stop   = 1'($urandom);
            end
            step();
        end
        start = 1'b0;
        check_idle(tag);
    endtask

    initial begin
        vec_t  tbl [4];
        vec_t  rv;
        bits_t bb;
        int    nb;
        int    waited;

        tbl[0] = '{d: 8'h55, len: 2'd3, pe: 1'b0, po: 1'b0, ts: 1'b0, bits: 12'h2AA, nbits: 10};
        tbl[1] = '{d: 8'h07, len: 2'd0, pe: 1'b1, po: 1'b0, ts: 1'b1, bits: 12'h1CE, nbits: 9};
        tbl[2] = '{d: 8'h07, len: 2'd0, pe: 1'b1, po: 1'b1, ts: 1'b1, bits: 12'h18E, nbits: 9};
        tbl[3] = '{d: 8'h3C, len: 2'd3, pe: 1'b1, po: 1'b0, ts: 1'b0, bits: 12'h478, nbits: 11};

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset_n = 1'b1;
        step();
        check_idle("post_reset");

        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i], 1'b0);
        end
        run_frame("vec1_poke", tbl[1], 1'b1);

        // Back-to-back with start held high: two 0xA5 8N1 frames with no idle gap.
        model_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, bb, nb);
        data = 8'hA5; data_len = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        start = 1'b1;
        step();
        for (int k = 0; k < 2 * nb * CLK_DIV; k++) begin
            chk("b2b.txd", 32'(txd), 32'(bb[(k % (nb * CLK_DIV)) / CLK_DIV]));
            chk("b2b.busy", 32'(busy), 32'd1);
            chk("b2b.frame_done", 32'(frame_done), 32'((k % (nb * CLK_DIV)) == nb * CLK_DIV - 1));
            if (k == nb * CLK_DIV) chk("b2b.second_start", 32'(phase), 32'd1);
            if (k == nb * CLK_DIV + 30) start = 1'b0;
            step();
        end
        check_idle("b2b");

        // clear during DATA at bit_idx 3, with a simultaneous start that must be ignored.
        data = 8'hFF; data_len = 2'd3; parity_en = 1'b0; two_stop = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        waited = 0;
        while (!(phase == 3'd2 && bit_idx == 3'd3) && waited < 100) begin
            step();
            waited++;
        end
        chk("clear.reach_bit3", 32'(waited < 100), 32'd1);
        clear = 1'b1;
        start = 1'b1;
        chk("clear.no_done_before", 32'(frame_done), 32'd0);
        step();
        clear = 1'b0;
        start = 1'b0;
        check_idle("clear");
        for (int k = 0; k < 3 * CLK_DIV; k++) begin
            step();
            chk("clear.stays_idle", 32'(phase), 32'd0);
            chk("clear.no_done", 32'(frame_done), 32'd0);
        end

        // Asynchronous reset during PARITY, then a clean 0x3C 8E1 frame.
        data = 8'h55; data_len = 2'd3; parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        waited = 0;
        while (phase != 3'd3 && waited < 100) begin
            step();
            waited++;
        end
        chk("rst.reach_parity", 32'(waited < 100), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("rst_async");
        step();
        check_idle("rst_held");
        #2;
        reset_n = 1'b1;
        step();
        run_frame("rst_after", tbl[3], 1'b0);

        // Randomized frames against the reference model, with noise on inputs mid-frame.
        for (int i = 0; i < 20; i++) begin
            rv.d   = 8'($urandom);
            rv.len = 2'($urandom);
            rv.pe  = 1'($urandom);
            rv.po  = 1'($urandom);
            rv.ts  = 1'($urandom);
            model_frame(rv.d, rv.len, rv.pe, rv.po, rv.ts, bb, nb);
            rv.bits  = bb;
            rv.nbits = nb;
            run_frame($sformatf("rnd%0d", i), rv, 1'b1);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
